// File: rtl/boreal_feature_normalizer.sv
// Serial 8-channel EMA offset removal + Q8.8 gain, one channel per cycle, atomic 128-bit output.
// Build option: define BOREAL_NORM_SAT_EN to saturate results instead of wrapping to 16 bits.
module boreal_feature_normalizer #(
    parameter int ALPHA_SHIFT = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] samples,
    input  logic         freeze,
    output logic [127:0] features,
    output logic         out_valid,
    input  logic [4:0]   host_addr,
    input  logic [15:0]  host_din,
    input  logic         host_we
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_idx;
    logic [127:0]        r_samples;
    logic                r_freeze;
    logic [127:0]        r_shadow;
    logic [127:0]        r_features;
    logic                r_seeded;
    logic signed [15:0]  r_gain [8];
    logic signed [23:0]  r_mean [8];

    logic signed [15:0]  w_x;
    logic signed [23:0]  w_mean;
    logic signed [23:0]  w_x_q;
    logic signed [15:0]  w_m;
    logic signed [16:0]  w_d;
    logic signed [32:0]  w_p;
    logic signed [24:0]  w_r;
    logic signed [15:0]  w_y;
    logic signed [24:0]  w_e;
    logic signed [24:0]  w_mean_sum;
    logic [127:0]        w_shadow_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_idx == 3'd7) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign features  = r_features;

    // Datapath for the channel selected by r_idx; always uses pre-write gain/mean.
    assign w_x        = r_samples[{r_idx, 4'h0} +: 16];
    assign w_mean     = r_mean[r_idx];
    assign w_x_q      = {w_x, 8'h00};
    assign w_m        = w_mean[23:8];
    assign w_d        = 17'(w_x) - 17'(w_m);
    assign w_p        = 33'(w_d) * 33'(r_gain[r_idx]);
    assign w_r        = 25'(w_p >>> 8);
    assign w_e        = 25'(w_x_q) - 25'(w_mean);
    assign w_mean_sum = 25'(w_mean) + (w_e >>> ALPHA_SHIFT);

    always_comb begin
        w_y = '0;
        if (r_seeded) begin
`ifdef BOREAL_NORM_SAT_EN
            if (w_r > 25'sd32767)
                w_y = 16'sh7fff;
            else if (w_r < -25'sd32768)
                w_y = 16'sh8000;
            else
                w_y = 16'(w_r);
`else
            w_y = 16'(w_r);
`endif
        end
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[{r_idx, 4'h0} +: 16] = w_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_samples  <= '0;
            r_freeze   <= 1'b0;
            r_shadow   <= '0;
            r_features <= '0;
            r_seeded   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_gain[i] <= 16'sh0100;
                r_mean[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && in_valid) begin
                r_samples <= samples;
                r_freeze  <= freeze;
                r_idx     <= '0;
            end
            if (r_state == S_RUN) begin
                r_idx    <= r_idx + 3'd1;
                r_shadow <= w_shadow_nxt;
                // Last channel goes straight into the output so the whole vector lands together.
                if (r_idx == 3'd7)
                    r_features <= w_shadow_nxt;
                if (!r_seeded)
                    r_mean[r_idx] <= w_x_q;
                else if (!r_freeze)
                    r_mean[r_idx] <= 24'(w_mean_sum);
            end
            if (r_state == S_DONE)
                r_seeded <= 1'b1;
            // Placed last so a host write beats the same-cycle EMA update.
            if (host_we && !host_addr[4]) begin
                if (!host_addr[3]) begin
                    r_gain[host_addr[2:0]] <= host_din;
                end else begin
                    r_mean[host_addr[2:0]] <= {host_din, 8'h00};
                    r_seeded               <= 1'b1;
                end
            end
        end
    end

endmodule
